pipeline_hazard_ctrl: RTL and testbench
=======================================

Name: pipeline_hazard_ctrl

Overview:
Central stall/flush/forwarding controller for the 5-stage PSRV32 pipeline.
- Watches the source operands of the instruction in decode, the destination registers in EX and MEM, branch resolution in EX, and the data-memory handshake in MEM.
- Drives the PC/IF-ID write enables, the ID-EX bubble, the IF-ID flush and the EX-MEM hold.
- Registers the forwarding selects that the execute stage uses one cycle later.

Parameters:
- FLUSH_CYCLES, 1, number of cycles IF-ID is flushed after a redirect (min 1; covers fetch latency).
- CNT_W, 16, width of the saturating stall-cycle counter.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  synchronous active-low reset
- id_valid_i  in  1  decode holds a valid instruction
- id_opcode_i  in  7  decode opcode
- id_rs1_i  in  5  decode rs1 address
- id_rs2_i  in  5  decode rs2 address
- ex_valid_i  in  1  EX holds a valid instruction
- ex_rd_i  in  5  EX destination
- ex_reg_write_i  in  1  EX writes the register file
- ex_mem_read_i  in  1  EX instruction is a LOAD
- mem_valid_i  in  1  MEM holds a valid instruction
- mem_rd_i  in  5  MEM destination
- mem_reg_write_i  in  1  MEM writes the register file
- branch_taken_i  in  1  EX resolved a taken branch/JAL/JALR (redirect)
- dmem_req_i  in  1  MEM issues a data-memory access this cycle
- dmem_ready_i  in  1  data memory completes the access
- pc_write_o  out  1  PC register enable
- if_id_write_o  out  1  IF-ID register enable
- if_id_flush_o  out  1  IF-ID loads a NOP
- id_ex_bubble_o  out  1  ID-EX loads a NOP
- ex_mem_hold_o  out  1  freeze ID-EX, EX-MEM, MEM-WB
- fwd_a_o  out  2  EX operand-A select: 00 regfile, 01 from EX-MEM, 10 from MEM-WB
- fwd_b_o  out  2  same for operand B
- state_o  out  2  FSM state: 00 RUN, 01 MEM_WAIT, 10 FLUSH
- stall_cnt_o  out  CNT_W  saturating count of cycles with pc_write_o=0

Behaviour:
- Reset (rst_ni=0 at posedge):
  - state=RUN; flush counter 0; fwd_a_o/fwd_b_o=00; stall_cnt_o=0.
  - While rst_ni=0, combinational outputs are forced: pc_write_o=0, if_id_write_o=0, if_id_flush_o=1, id_ex_bubble_o=1, ex_mem_hold_o=0.
  - Reset mid-MEM_WAIT or mid-FLUSH aborts to RUN.
- Operand use, decoded from id_opcode_i:
  - LUI, AUIPC, JAL use neither rs1 nor rs2.
  - LOAD, OP-IMM, JALR use rs1 only.
  - STORE, BRANCH, OP use both.
  - Any other opcode uses neither.
  - Register x0 never creates a hazard or a forward.
- load_use = id_valid_i & ex_valid_i & ex_mem_read_i & ex_rd_i≠0 & (rs1 used & id_rs1_i==ex_rd_i | rs2 used & id_rs2_i==ex_rd_i).
- Default RUN outputs: pc_write=1, if_id_write=1, all others 0.
- RUN priority, highest first:
  1. dmem_req_i & !dmem_ready_i:
     - ex_mem_hold=1, pc_write=0, if_id_write=0, no bubble, no flush; next state MEM_WAIT.
     - dmem_req_i & dmem_ready_i in the same cycle is a zero-wait access: no hold.
  2. branch_taken_i:
     - pc_write=1, if_id_flush=1, id_ex_bubble=1.
     - If FLUSH_CYCLES>1: next state FLUSH, counter=FLUSH_CYCLES-1.
     - A redirect overrides load_use.
  3. load_use:
     - pc_write=0, if_id_write=0, id_ex_bubble=1 for exactly one cycle; the hazard clears naturally next cycle.
- MEM_WAIT:
  - Outputs as in RUN case 1 while dmem_ready_i=0.
  - On dmem_ready_i=1: hold released this cycle, cases 2/3 evaluated with RUN rules this cycle, next state RUN or FLUSH.
  - branch_taken_i is ignored until release; EX is frozen, so the signal persists.
- FLUSH:
  - if_id_flush=1, id_ex_bubble=1, pc_write=1.
  - Counter decrements each cycle; RUN when it reaches 1→0.
  - A new branch_taken_i cannot occur (EX is bubbled).
  - dmem_req stall still has priority: enter MEM_WAIT; the remaining flush count is lost, which is acceptable because the redirect has already been fetched.
- Forwarding registers, updated on posedge only when the instruction advances ID→EX (if_id_write_o=1 & !id_ex_bubble_o & !ex_mem_hold_o):
  - fwd_a = 01 if ex_valid & ex_reg_write & ex_rd≠0 & ex_rd==rs1 & !ex_mem_read.
  - else 10 if mem_valid & mem_reg_write & mem_rd≠0 & mem_rd==rs1.
  - else 00.
  - fwd_b is the same with rs2.
  - Unused operand → 00.
  - On a bubble cycle: cleared to 00. On hold: unchanged.
- stall_cnt_o increments when pc_write_o=0 and saturates at all-ones.

Decomposition:
- Shared package psrv32_pkg holds:
  - opcode constants (OPC_LUI 0110111, OPC_AUIPC 0010111, OPC_JAL 1101111, OPC_JALR 1100111, OPC_BRANCH 1100011, OPC_LOAD 0000011, OPC_STORE 0100011, OPC_OPIMM 0010011, OPC_OP 0110011);
  - state encodings;
  - forward-select encodings.
- One sub-module, hazard_operand_use: opcode → {uses_rs1, uses_rs2}, purely combinational, reused by decode.

Test Plan:
1. Load-use: EX LOAD rd=x5, ID ADD rs1=x5 → one cycle pc_write=0, id_ex_bubble=1; next advance fwd_a_o=10.
2. EX ADDI rd=x7 (non-load), ID SUB rs2=x7 → no stall; fwd_b_o=01 after the edge. Repeat with rd=x0 → fwd_b_o=00.
3. FLUSH_CYCLES=2: branch_taken_i pulse → if_id_flush_o=1 for 2 cycles, state_o 00→10→00, pc_write_o stays 1.
4. dmem_req_i with ready after 3 cycles → ex_mem_hold_o=1 for 3 cycles, state_o=01, stall_cnt_o +3; branch_taken_i held during the wait flushes on the release cycle.
5. Simultaneous load_use and branch_taken_i → flush wins, no stall cycle, stall_cnt_o unchanged.
6. Assert rst_ni=0 during MEM_WAIT → next cycle state_o=00, fwd=00, stall_cnt_o=0, pc_write_o=0 while in reset.

Source files
------------

// File: rtl/psrv32_pkg.sv
// Shared PSRV32 pipeline definitions: opcodes, hazard FSM states, forward selects.
// Latency: n/a (constants, types and a pure combinational helper).
// Backpressure: n/a.
package psrv32_pkg;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    typedef enum logic [1:0] {
        ST_RUN      = 2'b00,
        ST_MEM_WAIT = 2'b01,
        ST_FLUSH    = 2'b10
    } hz_state_t;

    typedef enum logic [1:0] {
        FWD_RF    = 2'b00,
        FWD_EXMEM = 2'b01,
        FWD_MEMWB = 2'b10
    } fwd_sel_t;

    // EX-MEM wins over MEM-WB because it holds the younger result; a load in
    // EX has no data yet, so it never forwards from EX-MEM.
    function automatic fwd_sel_t fwd_select(
        input logic       used,
        input logic [4:0] rs,
        input logic       ex_valid,
        input logic       ex_reg_write,
        input logic       ex_mem_read,
        input logic [4:0] ex_rd,
        input logic       mem_valid,
        input logic       mem_reg_write,
        input logic [4:0] mem_rd
    );
        fwd_sel_t sel;
        sel = FWD_RF;
        if (used && rs != 5'd0) begin
            if (ex_valid && ex_reg_write && !ex_mem_read && ex_rd == rs) begin
                sel = FWD_EXMEM;
            end else if (mem_valid && mem_reg_write && mem_rd == rs) begin
                sel = FWD_MEMWB;
            end
        end
        return sel;
    endfunction

endpackage

// File: rtl/hazard_operand_use.sv
// Decodes which source registers an opcode actually reads.
// Latency: purely combinational.
// Backpressure: none.
module hazard_operand_use
    import psrv32_pkg::*;
(
    input  logic [6:0] opcode,
    output logic       uses_rs1,
    output logic       uses_rs2
);

    // Opcode class to operand usage; unknown opcodes read nothing.
    always_comb begin
        uses_rs1 = 1'b0;
        uses_rs2 = 1'b0;
        case (opcode)
            OPC_LOAD, OPC_OPIMM, OPC_JALR: begin
                uses_rs1 = 1'b1;
            end
            OPC_STORE, OPC_BRANCH, OPC_OP: begin
                uses_rs1 = 1'b1;
                uses_rs2 = 1'b1;
            end
            OPC_LUI, OPC_AUIPC, OPC_JAL: begin
                uses_rs1 = 1'b0;
            end
            default: begin
                uses_rs2 = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush/forward controller for the 5-stage PSRV32 pipeline.
// Latency: enables/flush/bubble/hold combinational; forward selects registered (used next cycle).
// Backpressure: an unready data-memory access freezes the back end and stalls fetch until ready.
module pipeline_hazard_ctrl
    import psrv32_pkg::*;
#(
    parameter int unsigned FLUSH_CYCLES = 1,
    parameter int unsigned CNT_W        = 16
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             id_valid_i,
    input  logic [6:0]       id_opcode_i,
    input  logic [4:0]       id_rs1_i,
    input  logic [4:0]       id_rs2_i,
    input  logic             ex_valid_i,
    input  logic [4:0]       ex_rd_i,
    input  logic             ex_reg_write_i,
    input  logic             ex_mem_read_i,
    input  logic             mem_valid_i,
    input  logic [4:0]       mem_rd_i,
    input  logic             mem_reg_write_i,
    input  logic             branch_taken_i,
    input  logic             dmem_req_i,
    input  logic             dmem_ready_i,
    output logic             pc_write_o,
    output logic             if_id_write_o,
    output logic             if_id_flush_o,
    output logic             id_ex_bubble_o,
    output logic             ex_mem_hold_o,
    output logic [1:0]       fwd_a_o,
    output logic [1:0]       fwd_b_o,
    output logic [1:0]       state_o,
    output logic [CNT_W-1:0] stall_cnt_o
);

    localparam int unsigned FC_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

    hz_state_t         state_q, state_d;
    logic [FC_W-1:0]   flush_cnt_q, flush_cnt_d;
    fwd_sel_t          fwd_a_q, fwd_b_q, fwd_a_d, fwd_b_d;
    logic [CNT_W-1:0]  stall_cnt_q;
    logic              use_rs1, use_rs2;
    logic              load_use, mem_stall, id_advance;

    hazard_operand_use u_operand_use (
        .opcode   (id_opcode_i),
        .uses_rs1 (use_rs1),
        .uses_rs2 (use_rs2)
    );

    assign load_use = id_valid_i & ex_valid_i & ex_mem_read_i & (ex_rd_i != 5'd0)
                    & ((use_rs1 & (id_rs1_i == ex_rd_i)) | (use_rs2 & (id_rs2_i == ex_rd_i)));

    // Once waiting, only ready matters: the request is frozen in MEM anyway.
    assign mem_stall = (state_q == ST_MEM_WAIT) ? !dmem_ready_i : (dmem_req_i & !dmem_ready_i);

    assign id_advance = if_id_write_o & !id_ex_bubble_o & !ex_mem_hold_o;

    assign fwd_a_d = fwd_select(use_rs1, id_rs1_i, ex_valid_i, ex_reg_write_i, ex_mem_read_i,
                                ex_rd_i, mem_valid_i, mem_reg_write_i, mem_rd_i);
    assign fwd_b_d = fwd_select(use_rs2, id_rs2_i, ex_valid_i, ex_reg_write_i, ex_mem_read_i,
                                ex_rd_i, mem_valid_i, mem_reg_write_i, mem_rd_i);

    // Next state and pipeline controls: memory stall > flush/redirect > load-use.
    always_comb begin
        pc_write_o     = 1'b1;
        if_id_write_o  = 1'b1;
        if_id_flush_o  = 1'b0;
        id_ex_bubble_o = 1'b0;
        ex_mem_hold_o  = 1'b0;
        state_d        = state_q;
        flush_cnt_d    = flush_cnt_q;
        if (!rst_ni) begin
            pc_write_o     = 1'b0;
            if_id_write_o  = 1'b0;
            if_id_flush_o  = 1'b1;
            id_ex_bubble_o = 1'b1;
            state_d        = ST_RUN;
            flush_cnt_d    = '0;
        end else if (mem_stall) begin
            ex_mem_hold_o = 1'b1;
            pc_write_o    = 1'b0;
            if_id_write_o = 1'b0;
            state_d       = ST_MEM_WAIT;
            flush_cnt_d   = '0;
        end else if (state_q == ST_FLUSH) begin
            if_id_flush_o  = 1'b1;
            id_ex_bubble_o = 1'b1;
            flush_cnt_d    = flush_cnt_q - FC_W'(1);
            state_d        = (flush_cnt_q == FC_W'(1)) ? ST_RUN : ST_FLUSH;
        end else if (branch_taken_i) begin
            if_id_flush_o  = 1'b1;
            id_ex_bubble_o = 1'b1;
            if (FLUSH_CYCLES > 1) begin
                state_d     = ST_FLUSH;
                flush_cnt_d = FC_W'(FLUSH_CYCLES - 1);
            end else begin
                state_d = ST_RUN;
            end
        end else begin
            state_d = ST_RUN;
            if (load_use) begin
                pc_write_o     = 1'b0;
                if_id_write_o  = 1'b0;
                id_ex_bubble_o = 1'b1;
            end
        end
    end

    // State register, forward selects and saturating stall counter.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q     <= ST_RUN;
            flush_cnt_q <= '0;
            fwd_a_q     <= FWD_RF;
            fwd_b_q     <= FWD_RF;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            flush_cnt_q <= flush_cnt_d;
            if (id_advance) begin
                fwd_a_q <= fwd_a_d;
                fwd_b_q <= fwd_b_d;
            end else if (id_ex_bubble_o) begin
                fwd_a_q <= FWD_RF;
                fwd_b_q <= FWD_RF;
            end
            if (!pc_write_o && stall_cnt_q != {CNT_W{1'b1}}) begin
                stall_cnt_q <= stall_cnt_q + CNT_W'(1);
            end
        end
    end

    assign fwd_a_o     = fwd_a_q;
    assign fwd_b_o     = fwd_b_q;
    assign state_o     = state_q;
    assign stall_cnt_o = stall_cnt_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed and random stimulus for the hazard controller against a reference model.
// Latency: comb outputs checked mid-cycle, registered outputs checked against model state.
// Backpressure: data-memory ready stalls modelled as a waiting flag.
module tb_pipeline_hazard_ctrl;

    localparam int FC = 2;
    localparam int CW = 5;

    logic clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    logic          rst_ni, id_valid_i, ex_valid_i, ex_reg_write_i, ex_mem_read_i;
    logic          mem_valid_i, mem_reg_write_i, branch_taken_i, dmem_req_i, dmem_ready_i;
    logic [6:0]    id_opcode_i;
    logic [4:0]    id_rs1_i, id_rs2_i, ex_rd_i, mem_rd_i;
    logic          pc_write_o, if_id_write_o, if_id_flush_o, id_ex_bubble_o, ex_mem_hold_o;
    logic [1:0]    fwd_a_o, fwd_b_o, state_o;
    logic [CW-1:0] stall_cnt_o;

    pipeline_hazard_ctrl #(.FLUSH_CYCLES(FC), .CNT_W(CW)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .id_valid_i(id_valid_i), .id_opcode_i(id_opcode_i),
        .id_rs1_i(id_rs1_i), .id_rs2_i(id_rs2_i), .ex_valid_i(ex_valid_i), .ex_rd_i(ex_rd_i),
        .ex_reg_write_i(ex_reg_write_i), .ex_mem_read_i(ex_mem_read_i),
        .mem_valid_i(mem_valid_i), .mem_rd_i(mem_rd_i), .mem_reg_write_i(mem_reg_write_i),
        .branch_taken_i(branch_taken_i), .dmem_req_i(dmem_req_i), .dmem_ready_i(dmem_ready_i),
        .pc_write_o(pc_write_o), .if_id_write_o(if_id_write_o), .if_id_flush_o(if_id_flush_o),
        .id_ex_bubble_o(id_ex_bubble_o), .ex_mem_hold_o(ex_mem_hold_o),
        .fwd_a_o(fwd_a_o), .fwd_b_o(fwd_b_o), .state_o(state_o), .stall_cnt_o(stall_cnt_o)
    );

    int total = 0;
    int bad   = 0;

    // Reference model: waiting flag, remaining flush cycles, forward selects, stall count.
    bit         m_wait;
    int         m_flush_left;
    logic [1:0] m_fa, m_fb;
    int         m_cnt;
    logic       e_pc, e_ifw, e_fl, e_bub, e_hold, e_stall;

    logic [6:0] opc_tab [10] = '{7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111, 7'b1100011,
                                  7'b0000011, 7'b0100011, 7'b0010011, 7'b0110011, 7'b1110011};

    // {reads rs1, reads rs2}
    function automatic logic [1:0] uses(input logic [6:0] opc);
        case (opc)
            7'b0000011, 7'b0010011, 7'b1100111: return 2'b10;
            7'b0100011, 7'b1100011, 7'b0110011: return 2'b11;
            default:                            return 2'b00;
        endcase
    endfunction

    function automatic logic [1:0] fwd(input logic used, input logic [4:0] rs);
        if (!used || rs == 5'd0) return 2'b00;
        if (ex_valid_i && ex_reg_write_i && !ex_mem_read_i && ex_rd_i == rs) return 2'b01;
        if (mem_valid_i && mem_reg_write_i && mem_rd_i == rs) return 2'b10;
        return 2'b00;
    endfunction

    function automatic logic [1:0] exp_state();
        if (m_wait) return 2'b01;
        if (m_flush_left > 0) return 2'b10;
        return 2'b00;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        total++;
        assert (obs === exp_v) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic model_comb();
        logic [1:0] u;
        bit lu;
        u  = uses(id_opcode_i);
        lu = id_valid_i && ex_valid_i && ex_mem_read_i && ex_rd_i != 5'd0 &&
             ((u[1] && id_rs1_i == ex_rd_i) || (u[0] && id_rs2_i == ex_rd_i));
        e_stall = m_wait ? !dmem_ready_i : (dmem_req_i && !dmem_ready_i);
        {e_pc, e_ifw, e_fl, e_bub, e_hold} = 5'b11000;
        if (!rst_ni)                                    {e_pc, e_ifw, e_fl, e_bub, e_hold} = 5'b00110;
        else if (e_stall)                               {e_pc, e_ifw, e_fl, e_bub, e_hold} = 5'b00001;
        else if (m_flush_left > 0 || branch_taken_i)    {e_pc, e_ifw, e_fl, e_bub, e_hold} = 5'b11110;
        else if (lu)                                    {e_pc, e_ifw, e_fl, e_bub, e_hold} = 5'b00010;
    endtask

    task automatic model_tick();
        logic [1:0] u;
        if (!rst_ni) begin
            m_wait = 0; m_flush_left = 0; m_fa = 2'b00; m_fb = 2'b00; m_cnt = 0;
        end else begin
            if (!e_pc && m_cnt < (1 << CW) - 1) m_cnt++;
            if (e_ifw && !e_bub && !e_hold) begin
                u = uses(id_opcode_i);
                m_fa = fwd(u[1], id_rs1_i);
                m_fb = fwd(u[0], id_rs2_i);
            end else if (e_bub) begin
                m_fa = 2'b00; m_fb = 2'b00;
            end
            if (e_stall) begin
                m_wait = 1; m_flush_left = 0;
            end else begin
                m_wait = 0;
                if (m_flush_left > 0) m_flush_left--;
                else if (branch_taken_i) m_flush_left = FC - 1;
            end
        end
    endtask

    task automatic cycle();
        @(negedge clk_i);
        model_comb();
        chk("pc_write", pc_write_o, e_pc);
        chk("if_id_write", if_id_write_o, e_ifw);
        chk("if_id_flush", if_id_flush_o, e_fl);
        chk("id_ex_bubble", id_ex_bubble_o, e_bub);
        chk("ex_mem_hold", ex_mem_hold_o, e_hold);
        chk("fwd_a", fwd_a_o, m_fa);
        chk("fwd_b", fwd_b_o, m_fb);
        chk("state", state_o, exp_state());
        chk("stall_cnt", stall_cnt_o, m_cnt);
        @(posedge clk_i);
        model_tick();
        #1;
    endtask

    task automatic idle();
        rst_ni = 1; id_valid_i = 0; id_opcode_i = 7'b0010011; id_rs1_i = 0; id_rs2_i = 0;
        ex_valid_i = 0; ex_rd_i = 0; ex_reg_write_i = 0; ex_mem_read_i = 0;
        mem_valid_i = 0; mem_rd_i = 0; mem_reg_write_i = 0;
        branch_taken_i = 0; dmem_req_i = 0; dmem_ready_i = 0;
    endtask

    initial begin
        int c0;
        idle();
        rst_ni = 0;
        m_wait = 0; m_flush_left = 0; m_fa = 2'b00; m_fb = 2'b00; m_cnt = 0;
        repeat (2) @(posedge clk_i);
        #1;
        cycle();                            // forced outputs while in reset
        idle();
        cycle();

        // Load-use on rs1, then the load sits in MEM and forwards from MEM-WB.
        id_valid_i = 1; id_opcode_i = 7'b0110011; id_rs1_i = 5; id_rs2_i = 1;
        ex_valid_i = 1; ex_rd_i = 5; ex_reg_write_i = 1; ex_mem_read_i = 1;
        cycle();
        ex_valid_i = 0; ex_mem_read_i = 0; mem_valid_i = 1; mem_rd_i = 5; mem_reg_write_i = 1;
        cycle();
        chk("tp1_fwd_a", fwd_a_o, 2'b10);

        // ALU result in EX forwards from EX-MEM; x0 never forwards.
        idle();
        id_valid_i = 1; id_opcode_i = 7'b0110011; id_rs1_i = 3; id_rs2_i = 7;
        ex_valid_i = 1; ex_rd_i = 7; ex_reg_write_i = 1;
        cycle();
        chk("tp2_fwd_b", fwd_b_o, 2'b01);
        ex_rd_i = 0; id_rs2_i = 0;
        cycle();
        chk("tp2_fwd_b_x0", fwd_b_o, 2'b00);

        // Redirect: two flush cycles, state RUN -> FLUSH -> RUN.
        idle();
        branch_taken_i = 1;
        cycle();
        idle();
        chk("tp3_state_flush", state_o, 2'b10);
        chk("tp3_flush_2nd", if_id_flush_o, 1'b1);
        cycle();
        chk("tp3_state_run", state_o, 2'b00);
        cycle();

        // Three-cycle memory wait with a redirect pending during it.
        c0 = m_cnt;
        dmem_req_i = 1;
        cycle();
        chk("tp4_state_wait", state_o, 2'b01);
        branch_taken_i = 1;
        cycle();
        cycle();
        dmem_ready_i = 1;
        cycle();
        chk("tp4_stall_cnt", stall_cnt_o, c0 + 3);
        chk("tp4_state_flush", state_o, 2'b10);
        idle();
        cycle();
        cycle();

        // Redirect coinciding with load-use: flush wins, no stall counted.
        c0 = m_cnt;
        id_valid_i = 1; id_opcode_i = 7'b0000011; id_rs1_i = 9;
        ex_valid_i = 1; ex_rd_i = 9; ex_reg_write_i = 1; ex_mem_read_i = 1;
        branch_taken_i = 1;
        cycle();
        chk("tp5_stall_cnt", stall_cnt_o, c0);
        chk("tp5_state", state_o, 2'b10);
        idle();
        cycle();

        // Reset while waiting on memory aborts to RUN with cleared state.
        dmem_req_i = 1;
        cycle();
        rst_ni = 0;
        cycle();
        chk("tp6_state", state_o, 2'b00);
        chk("tp6_fwd_a", fwd_a_o, 2'b00);
        chk("tp6_stall_cnt", stall_cnt_o, 0);
        chk("tp6_pc_write_in_reset", pc_write_o, 1'b0);
        idle();
        cycle();

        // Long memory stall drives the counter into saturation.
        dmem_req_i = 1;
        repeat (40) cycle();
        chk("sat_stall_cnt", stall_cnt_o, (1 << CW) - 1);
        dmem_ready_i = 1;
        cycle();
        idle();
        cycle();

        // Random traffic.
        for (int i = 0; i < 600; i++) begin
            rst_ni          = ($urandom_range(0, 59) != 0);
            id_valid_i      = ($urandom_range(0, 3) != 0);
            id_opcode_i     = opc_tab[$urandom_range(0, 9)];
            id_rs1_i        = 5'($urandom_range(0, 7));
            id_rs2_i        = 5'($urandom_range(0, 7));
            ex_valid_i      = ($urandom_range(0, 3) != 0);
            ex_rd_i         = 5'($urandom_range(0, 7));
            ex_reg_write_i  = ($urandom_range(0, 3) != 0);
            ex_mem_read_i   = ($urandom_range(0, 2) == 0);
            mem_valid_i     = ($urandom_range(0, 3) != 0);
            mem_rd_i        = 5'($urandom_range(0, 7));
            mem_reg_write_i = ($urandom_range(0, 3) != 0);
            branch_taken_i  = (m_flush_left == 0 || m_wait) && ($urandom_range(0, 6) == 0);
            dmem_req_i      = ($urandom_range(0, 4) == 0);
            dmem_ready_i    = ($urandom_range(0, 1) == 0);
            cycle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
